// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier.
package mul_pkg;

    // op encodings, as presented on the op port
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // Number of shift-add steps, one per multiplier bit
    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mul_state_t;

    // Two's-complement magnitude of a 32-bit value when it is treated as negative
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
        return is_neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Per-group lookahead; ci carries the group carry into the next group
    always_comb begin
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;
        c  = '0;
        gg = '0;
        pp = '0;
        ci = cin_i;
        c[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            gg = g[4*k +: 4];
            pp = p[4*k +: 4];
            c[4*k+1] = gg[0] | (pp[0] & ci);
            c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
            c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | ((&pp[2:0]) & ci);
            ci       = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & ci);
            c[4*k+4] = ci;
        end
    end

    assign sum_o  = p ^ c[31:0];
    assign cout_o = c[32];

endmodule

// File: rtl/seq_mul32.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at accept, multiplied unsigned over
// 32 cycles through one cla32, and the sign is re-applied in a single FIX cycle.
module seq_mul32
    import mul_pkg::*;
#(
    parameter int ITERATIONS = MUL_ITERS  // only 32 is meaningful
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] LAST_CNT = 5'(ITERATIONS - 1);

    mul_state_t  state_q;
    logic [31:0] mcand_q;
    // High partial product. The architectural bit 32 of acc is always zero
    // after a shift, so only bits [31:0] are stored.
    logic [31:0] acc_q;
    logic [31:0] mplier_q;
    logic [4:0]  cnt_q;
    logic        neg_q;
    logic [1:0]  op_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;

    // Accept-time operand interpretation
    logic        s1_neg;
    logic        s2_neg;
    logic [31:0] mcand_d;
    logic [31:0] mplier_d;

    // Datapath
    logic [31:0] addend;
    logic [31:0] sum;
    logic        cout;
    logic [63:0] prod_mag;
    logic [63:0] prod_fix;

    // Signedness follows the op: rs1 signed for MULH/MULHSU, rs2 only for MULH
    always_comb begin
        s1_neg   = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && rs1[31];
        s2_neg   = (op == MUL_OP_MULH) && rs2[31];
        mcand_d  = mag32(rs1, s1_neg);
        mplier_d = mag32(rs2, s2_neg);
    end

    assign addend = mplier_q[0] ? mcand_q : 32'd0;

    cla32 u_cla (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // 64-bit negate only feeds the FIX-cycle result write
    assign prod_mag = {acc_q, mplier_q};
    assign prod_fix = neg_q ? (~prod_mag + 64'd1) : prod_mag;

    // Control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        neg_q    <= s1_neg ^ s2_neg;
                        op_q     <= op;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    // {cout, sum, mplier} >> 1 lands in {acc, mplier}
                    acc_q    <= {cout, sum[31:1]};
                    mplier_q <= {sum[0], mplier_q[31:1]};
                    if (cnt_q == LAST_CNT) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                FIX: begin
                    result_q <= (op_q == MUL_OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_mul32.sv
// Directed plus randomized checks of seq_mul32 against an arithmetic model.
module tb_seq_mul32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seq_mul32 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width product with the interpretation each op names
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (o)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; optionally poke a start at iteration `poke_at` (must be ignored).
    // Returns the cycle number on which done was seen. Leaves time inside the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at, output int done_cyc);
        int n;
        logic [31:0] exp;
        exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke_at) begin
                start = 1'b1; op = ~o; rs1 = $urandom; rs2 = $urandom;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            if (done || n > 60) break;
        end
        done_cyc = cyc;
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " result"}, 64'(result), 64'(exp));
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dc1, dc2, dc;
        logic [31:0] held;
        logic [31:0] a, b;
        logic [1:0]  o;

        // Reset state
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0, dc);
        chk("mul_7x6_const", 64'(result), 64'h2A);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("result_held", 64'(result), 64'h2A);

        run_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, dc);
        chk("mul_max_const", 64'(result), 64'h1);
        run_op("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, dc);
        chk("mulhu_max_const", 64'(result), 64'hFFFFFFFE);
        run_op("mulh_minmin", 2'b01, 32'h80000000, 32'h80000000, 0, dc);
        chk("mulh_minmin_const", 64'(result), 64'h40000000);
        run_op("mulh_m1m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, dc);
        chk("mulh_m1m1_const", 64'(result), 64'h0);
        run_op("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, dc);
        chk("mulhsu_m1_const", 64'(result), 64'hFFFFFFFF);
        run_op("mulhsu_min", 2'b10, 32'h80000000, 32'h00000003, 0, dc);
        run_op("mulh_mixed", 2'b01, 32'hFFFFFFF9, 32'h00000006, 0, dc);

        // start during busy is ignored
        run_op("ignored_start", 2'b00, 32'h12345678, 32'h9ABCDEF0, 10, dc);
        @(posedge clk); #1;
        chk("ignored_no_extra_busy", 64'(busy), 64'd0);
        chk("ignored_no_extra_done", 64'(done), 64'd0);

        // Back-to-back: second start in the done cycle
        run_op("b2b_first", 2'b11, 32'hDEADBEEF, 32'h01234567, 0, dc1);
        run_op("b2b_second", 2'b01, 32'h87654321, 32'hFEDCBA98, 0, dc2);
        chk("b2b_spacing", 64'(dc2 - dc1), 64'd34);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs1 = 32'hFFFF0000; rs2 = 32'h0000FFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midreset_no_done", 64'(done), 64'd0);
        run_op("post_reset_3x5", 2'b00, 32'd3, 32'd5, 0, dc);
        chk("post_reset_3x5_const", 64'(result), 64'hF);

        // Randomized ops, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = 32'h80000000;
                2: a = 32'd0;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op("rand", o, a, b, 0, dc);
            held = result;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk("rand_result_held", 64'(result), 64'(held));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
